// File: rtl/clock_set_ctrl.sv
// Time-set controller: button FSM, shadow hour/minute registers,
// counter freeze while setting and a one-cycle load on commit.
module clock_set_ctrl #(
  parameter int HOUR_MAX   = 23,
  parameter int MIN_MAX    = 59,
  parameter int TIMEOUT_S  = 10,
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       buttons,
  input  logic                             tick,
  input  logic [$clog2(HOUR_MAX+1)-1:0]    cur_hours,
  input  logic [$clog2(MIN_MAX+1)-1:0]     cur_mins,
  output logic [$clog2(HOUR_MAX+1)-1:0]    set_hours,
  output logic [$clog2(MIN_MAX+1)-1:0]     set_mins,
  output logic                             load,
  output logic                             run_en,
  output logic [1:0]                       mode,
  output logic                             blink
);

  localparam int HW = $clog2(HOUR_MAX + 1);
  localparam int MW = $clog2(MIN_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam int RW = $clog2(REPEAT_DLY + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [2:0]      btn_q, press;
  logic [TW-1:0]   idle, idle_n;
  logic [RW-1:0]   up_cnt, up_cnt_n;
  logic [RW-1:0]   dn_cnt, dn_cnt_n;
  logic [HW-1:0]   hours_n;
  logic [MW-1:0]   mins_n;
  logic            load_n, blink_n;
  logic            up_alone, dn_alone;
  logic            up_rpt, dn_rpt;
  logic            inc, dec, active;

  assign press    = buttons & ~btn_q;
  assign up_alone = buttons[1] & ~buttons[0];
  assign dn_alone = buttons[0] & ~buttons[1];
  assign up_rpt   = up_alone & ~press[1]
                  & (up_cnt == RW'(REPEAT_DLY));
  assign dn_rpt   = dn_alone & ~press[0]
                  & (dn_cnt == RW'(REPEAT_DLY));
  assign inc      = (press[1] | up_rpt) & ~buttons[0];
  assign dec      = (press[0] | dn_rpt) & ~buttons[1];
  assign active   = (|press) | up_rpt | dn_rpt;

  assign mode   = state;
  assign run_en = (state == RUN);

  // cnt==0 means idle; after a repeat step it reloads so the next
  // step lands exactly REPEAT_PER cycles later
  function automatic logic [RW-1:0] rpt_next(
    input logic          alone,
    input logic          pr,
    input logic          rpt,
    input logic [RW-1:0] cnt
  );
    if (!alone)          return '0;
    else if (pr)         return RW'(1);
    else if (rpt)        return RW'(REPEAT_DLY - REPEAT_PER + 1);
    else if (cnt != '0)  return cnt + 1'b1;
    else                 return '0;
  endfunction

  always_comb begin
    state_n  = state;
    hours_n  = set_hours;
    mins_n   = set_mins;
    load_n   = 1'b0;
    blink_n  = blink;
    idle_n   = idle;
    up_cnt_n = rpt_next(up_alone, press[1], up_rpt, up_cnt);
    dn_cnt_n = rpt_next(dn_alone, press[0], dn_rpt, dn_cnt);
    unique case (state)
      RUN: begin
        idle_n  = '0;
        blink_n = 1'b0;
        if (press[2]) begin
          state_n  = SET_HOUR;
          hours_n  = cur_hours;
          mins_n   = cur_mins;
          blink_n  = 1'b1;
          up_cnt_n = '0;
          dn_cnt_n = '0;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (press[2]) begin
          idle_n = '0;
          if (state == SET_HOUR) begin
            state_n  = SET_MIN;
            blink_n  = 1'b1;
            up_cnt_n = '0;
            dn_cnt_n = '0;
          end else begin
            state_n = RUN;
            load_n  = 1'b1;
            blink_n = 1'b0;
          end
        end else begin
          if (state == SET_HOUR) begin
            if (inc)
              hours_n = (set_hours == HW'(HOUR_MAX))
                      ? '0 : set_hours + 1'b1;
            else if (dec)
              hours_n = (set_hours == '0)
                      ? HW'(HOUR_MAX) : set_hours - 1'b1;
          end else begin
            if (inc)
              mins_n = (set_mins == MW'(MIN_MAX))
                     ? '0 : set_mins + 1'b1;
            else if (dec)
              mins_n = (set_mins == '0)
                     ? MW'(MIN_MAX) : set_mins - 1'b1;
          end
          if (active) begin
            idle_n = '0;
          end else if (tick) begin
            if (idle == TW'(TIMEOUT_S - 1)) begin
              state_n = RUN;
              idle_n  = '0;
              blink_n = 1'b0;
            end else begin
              idle_n = idle + 1'b1;
            end
          end
          if (tick && state_n != RUN)
            blink_n = ~blink;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      btn_q     <= 3'b111;
      set_hours <= '0;
      set_mins  <= '0;
      load      <= 1'b0;
      blink     <= 1'b0;
      idle      <= '0;
      up_cnt    <= '0;
      dn_cnt    <= '0;
    end else begin
      state     <= state_n;
      btn_q     <= buttons;
      set_hours <= hours_n;
      set_mins  <= mins_n;
      load      <= load_n;
      blink     <= blink_n;
      idle      <= idle_n;
      up_cnt    <= up_cnt_n;
      dn_cnt    <= dn_cnt_n;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table, directed corner cases,
// and random stimulus against a behavioural model.
module tb_clock_set_ctrl;

  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int TO  = 10;

  logic       clk, reset, tick, load, run_en, blink;
  logic [2:0] buttons;
  logic [4:0] cur_hours, set_hours;
  logic [5:0] cur_mins, set_mins;
  logic [1:0] mode;

  clock_set_ctrl #(
    .HOUR_MAX(23), .MIN_MAX(59), .TIMEOUT_S(TO),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (
    .clk(clk), .reset(reset), .buttons(buttons),
    .tick(tick), .cur_hours(cur_hours),
    .cur_mins(cur_mins), .set_hours(set_hours),
    .set_mins(set_mins), .load(load),
    .run_en(run_en), .mode(mode), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_mode, m_h, m_m, m_load, m_blink, m_idle;
  int k_up, k_dn;
  logic [2:0] m_prev;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Time-based model: hold age k counts edges since the press
  task automatic model(input logic [2:0] b,
                       input logic t, input logic r);
    logic [2:0] pr;
    bit ru, rd, inc, dec, act;
    if (r) begin
      m_mode = 0; m_h = 0; m_m = 0; m_load = 0;
      m_blink = 0; m_idle = 0; k_up = -1; k_dn = -1;
      m_prev = 3'b111;
      return;
    end
    pr = b & ~m_prev;
    m_prev = b;
    if (b[1] && !b[0])
      k_up = pr[1] ? 0 : (k_up >= 0 ? k_up + 1 : -1);
    else
      k_up = -1;
    if (b[0] && !b[1])
      k_dn = pr[0] ? 0 : (k_dn >= 0 ? k_dn + 1 : -1);
    else
      k_dn = -1;
    ru = k_up >= DLY && (k_up - DLY) % PER == 0;
    rd = k_dn >= DLY && (k_dn - DLY) % PER == 0;
    inc = (pr[1] || ru) && !b[0];
    dec = (pr[0] || rd) && !b[1];
    act = (pr != 0) || ru || rd;
    m_load = 0;
    if (m_mode == 0) begin
      if (pr[2]) begin
        m_mode = 1; m_h = int'(cur_hours);
        m_m = int'(cur_mins); m_blink = 1;
        m_idle = 0; k_up = -1; k_dn = -1;
      end
    end else if (pr[2]) begin
      if (m_mode == 1) begin
        m_mode = 2; m_blink = 1; m_idle = 0;
        k_up = -1; k_dn = -1;
      end else begin
        m_mode = 0; m_load = 1; m_blink = 0;
      end
    end else begin
      if (m_mode == 1) begin
        if (inc) m_h = (m_h + 1) % 24;
        else if (dec) m_h = (m_h + 23) % 24;
      end else begin
        if (inc) m_m = (m_m + 1) % 60;
        else if (dec) m_m = (m_m + 59) % 60;
      end
      if (act) m_idle = 0;
      else if (t) m_idle++;
      if (m_idle == TO) begin
        m_mode = 0; m_idle = 0; m_blink = 0;
      end else if (t) begin
        m_blink ^= 1;
      end
    end
  endtask

  task automatic step(input logic [2:0] b,
                      input logic t, input logic r);
    @(negedge clk);
    buttons = b; tick = t; reset = r;
    @(posedge clk);
    model(b, t, r);
    #1;
    chk("mode", 32'(mode), 32'(m_mode));
    chk("hours", 32'(set_hours), 32'(m_h));
    chk("mins", 32'(set_mins), 32'(m_m));
    chk("load", 32'(load), 32'(m_load));
    chk("run_en", 32'(run_en), 32'(m_mode == 0));
    chk("blink", 32'(blink), 32'(m_blink));
  endtask

  task automatic tap(input logic [2:0] b);
    step(b, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [2:0] b;
    int         md;
    int         h;
    int         m;
    logic       ld;
  } vec_t;

  vec_t tbl[20];
  int   ld_seen;

  initial begin
    tbl[0]  = '{3'b100, 1, 3, 7, 1'b0};
    tbl[1]  = '{3'b000, 1, 3, 7, 1'b0};
    tbl[2]  = '{3'b001, 1, 2, 7, 1'b0};
    tbl[3]  = '{3'b000, 1, 2, 7, 1'b0};
    tbl[4]  = '{3'b001, 1, 1, 7, 1'b0};
    tbl[5]  = '{3'b000, 1, 1, 7, 1'b0};
    tbl[6]  = '{3'b001, 1, 0, 7, 1'b0};
    tbl[7]  = '{3'b000, 1, 0, 7, 1'b0};
    tbl[8]  = '{3'b001, 1, 23, 7, 1'b0};
    tbl[9]  = '{3'b000, 1, 23, 7, 1'b0};
    tbl[10] = '{3'b011, 1, 23, 7, 1'b0};
    tbl[11] = '{3'b000, 1, 23, 7, 1'b0};
    tbl[12] = '{3'b010, 1, 0, 7, 1'b0};
    tbl[13] = '{3'b000, 1, 0, 7, 1'b0};
    tbl[14] = '{3'b100, 2, 0, 7, 1'b0};
    tbl[15] = '{3'b000, 2, 0, 7, 1'b0};
    tbl[16] = '{3'b010, 2, 0, 8, 1'b0};
    tbl[17] = '{3'b000, 2, 0, 8, 1'b0};
    tbl[18] = '{3'b100, 0, 0, 8, 1'b1};
    tbl[19] = '{3'b000, 0, 0, 8, 1'b0};

    buttons = 3'b111; tick = 1'b0; reset = 1'b1;
    cur_hours = 5'd3; cur_mins = 6'd7;
    model(3'b111, 1'b0, 1'b1);

    // held buttons through reset give no press
    step(3'b111, 1'b0, 1'b1);
    step(3'b111, 1'b0, 1'b1);
    step(3'b111, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_run_en", 32'(run_en), 1);
    chk("rst_load", 32'(load), 0);

    foreach (tbl[i]) begin
      step(tbl[i].b, 1'b0, 1'b0);
      chk("tbl_mode", 32'(mode), 32'(tbl[i].md));
      chk("tbl_hours", 32'(set_hours), 32'(tbl[i].h));
      chk("tbl_mins", 32'(set_mins), 32'(tbl[i].m));
      chk("tbl_load", 32'(load), 32'(tbl[i].ld));
    end

    cur_hours = 5'd13; cur_mins = 6'd45;
    tap(3'b100);
    repeat (11) tap(3'b010);
    chk("wrap_hours", 32'(set_hours), 0);
    tap(3'b100);
    repeat (46) tap(3'b001);
    chk("wrap_mins", 32'(set_mins), 59);
    step(3'b100, 1'b0, 1'b0);
    chk("commit_load", 32'(load), 1);
    chk("commit_h", 32'(set_hours), 0);
    chk("commit_m", 32'(set_mins), 59);
    step(3'b000, 1'b0, 1'b0);
    chk("load_1cyc", 32'(load), 0);

    cur_hours = 5'd1; cur_mins = 6'd2;
    tap(3'b100); tap(3'b100);
    ld_seen = 0;
    for (int i = 1; i <= TO; i++) begin
      step(3'b000, 1'b1, 1'b0);
      ld_seen |= int'(load);
      if (i == TO - 1) chk("to_before", 32'(mode), 2);
    end
    chk("to_mode", 32'(mode), 0);
    chk("to_run_en", 32'(run_en), 1);
    chk("to_no_load", 32'(ld_seen), 0);
    chk("to_keep_m", 32'(set_mins), 2);

    tap(3'b100); tap(3'b100);
    repeat (TO - 1) step(3'b000, 1'b1, 1'b0);
    step(3'b100, 1'b1, 1'b0);
    chk("to_mode_win", 32'(load), 1);
    chk("to_mode_run", 32'(mode), 0);
    step(3'b000, 1'b0, 1'b0);

    cur_hours = 5'd0; cur_mins = 6'd0;
    tap(3'b100); tap(3'b100);
    step(3'b010, 1'b0, 1'b0);
    repeat (40) step(3'b010, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    chk("repeat_mins", 32'(set_mins), 6);

    tap(3'b100); tap(3'b100);
    step(3'b000, 1'b0, 1'b1);
    chk("mid_rst_mode", 32'(mode), 0);
    chk("mid_rst_run", 32'(run_en), 1);
    chk("mid_rst_load", 32'(load), 0);
    chk("mid_rst_h", 32'(set_hours), 0);
    chk("mid_rst_m", 32'(set_mins), 0);
    chk("mid_rst_blink", 32'(blink), 0);
    step(3'b000, 1'b0, 1'b0);

    begin
      logic [2:0] b;
      b = 3'b000;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 15) == 0)
          b = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 31) == 0) begin
          cur_hours = 5'($urandom_range(0, 23));
          cur_mins  = 6'($urandom_range(0, 59));
        end
        step(b, 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 599) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
